// File: rtl/bpu_update_unit.sv
// Update side of the gshare direction predictor: a FIFO of prediction metadata in fetch order,
// popped on branch resolve to drive registered PHT/GHR write ports with the updated counter.
module bpu_update_unit #(
    parameter int unsigned IDX_W = 11,
    parameter int unsigned CTR_W = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     BPU__Stall,
    input  logic                     Flush,
    input  logic                     Pred_Valid,
    input  logic [IDX_W-1:0]         Pred_Index,
    input  logic [CTR_W-1:0]         Pred_Counter,
    output logic                     Pred_Ready,
    input  logic                     Resolve_Valid,
    input  logic                     Resolve_Taken,
    output logic [IDX_W-1:0]         PHT_Write_Index,
    output logic [CTR_W-1:0]         PHT_Write_Data,
    output logic                     PHT_Write_En,
    output logic                     GHR_Write_Data,
    output logic                     GHR_Write_En,
    output logic                     Mispredict,
    output logic                     Underflow_Err,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CTR_W-1:0] CtrMax = '1;
    localparam logic [CntW-1:0]  CntFull = CntW'(DEPTH);

    logic [IDX_W-1:0] idx_q [DEPTH];
    logic [IDX_W-1:0] idx_d [DEPTH];
    logic [CTR_W-1:0] ctr_q [DEPTH];
    logic [CTR_W-1:0] ctr_d [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [CTR_W-1:0] wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic             ghr_data_q, ghr_data_d;
    logic             mispred_q, mispred_d;
    logic             underflow_q, underflow_d;

    logic             empty, full, pop, push, underflow;
    logic [IDX_W-1:0] head_idx;
    logic [CTR_W-1:0] head_ctr;
    logic [CTR_W-1:0] new_ctr;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CntFull);
        pop       = !BPU__Stall && Resolve_Valid && !empty;
        underflow = !BPU__Stall && Resolve_Valid && empty;
        // A pop frees the head slot this cycle, so a push at full is still accepted.
        push      = !BPU__Stall && Pred_Valid && (!full || pop);
        head_idx  = idx_q[rd_ptr_q];
        head_ctr  = ctr_q[rd_ptr_q];
        if (Resolve_Taken) begin
            new_ctr = (head_ctr == CtrMax) ? head_ctr : head_ctr + CTR_W'(1);
        end else begin
            new_ctr = (head_ctr == '0) ? head_ctr : head_ctr - CTR_W'(1);
        end
    end

    always_comb begin
        idx_d       = idx_q;
        ctr_d       = ctr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = wr_en_q;
        ghr_data_d  = ghr_data_q;
        mispred_d   = mispred_q;
        underflow_d = underflow_q;

        if (pop) begin
            // Younger entries aliasing the same PHT slot must see the counter being written.
            for (int i = 0; i < DEPTH; i++) begin
                if (idx_q[i] == head_idx) begin
                    ctr_d[i] = new_ctr;
                end
            end
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push) begin
            idx_d[wr_ptr_q] = Pred_Index;
            ctr_d[wr_ptr_q] = (pop && (Pred_Index == head_idx)) ? new_ctr : Pred_Counter;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push) - CntW'(pop);

        if (!BPU__Stall) begin
            wr_en_d     = pop;
            mispred_d   = pop && (head_ctr[CTR_W-1] ^ Resolve_Taken);
            underflow_d = underflow;
            if (pop) begin
                wr_idx_d   = head_idx;
                wr_data_d  = new_ctr;
                ghr_data_d = Resolve_Taken;
            end
        end

        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
                ctr_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wr_idx_q    <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            ghr_data_q  <= 1'b0;
            mispred_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            ctr_q       <= ctr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            ghr_data_q  <= ghr_data_d;
            mispred_q   <= mispred_d;
            underflow_q <= underflow_d;
        end
    end

    assign Pred_Ready      = !full;
    assign Count           = count_q;
    assign PHT_Write_Index = wr_idx_q;
    assign PHT_Write_Data  = wr_data_q;
    assign PHT_Write_En    = wr_en_q;
    assign GHR_Write_Data  = ghr_data_q;
    assign GHR_Write_En    = wr_en_q;
    assign Mispredict      = mispred_q;
    assign Underflow_Err   = underflow_q;

endmodule

// File: tb/tb_bpu_update_unit.sv
// Directed bench for bpu_update_unit: reset, counter update, saturation, forwarding,
// full/wrap FIFO order, stall, flush, underflow and asynchronous reset.
module tb_bpu_update_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        BPU__Stall;
    logic        Flush;
    logic        Pred_Valid;
    logic [10:0] Pred_Index;
    logic [1:0]  Pred_Counter;
    logic        Pred_Ready;
    logic        Resolve_Valid;
    logic        Resolve_Taken;
    logic [10:0] PHT_Write_Index;
    logic [1:0]  PHT_Write_Data;
    logic        PHT_Write_En;
    logic        GHR_Write_Data;
    logic        GHR_Write_En;
    logic        Mispredict;
    logic        Underflow_Err;
    logic [3:0]  Count;

    int errors = 0;
    int checks = 0;

    logic [10:0] m_idx [$];
    logic [1:0]  m_ctr [$];

    bpu_update_unit #(.IDX_W(11), .CTR_W(2), .DEPTH(8)) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .BPU__Stall      (BPU__Stall),
        .Flush           (Flush),
        .Pred_Valid      (Pred_Valid),
        .Pred_Index      (Pred_Index),
        .Pred_Counter    (Pred_Counter),
        .Pred_Ready      (Pred_Ready),
        .Resolve_Valid   (Resolve_Valid),
        .Resolve_Taken   (Resolve_Taken),
        .PHT_Write_Index (PHT_Write_Index),
        .PHT_Write_Data  (PHT_Write_Data),
        .PHT_Write_En    (PHT_Write_En),
        .GHR_Write_Data  (GHR_Write_Data),
        .GHR_Write_En    (GHR_Write_En),
        .Mispredict      (Mispredict),
        .Underflow_Err   (Underflow_Err),
        .Count           (Count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? c : c + 2'd1;
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    task automatic push(input logic [10:0] idx, input logic [1:0] ctr);
        Pred_Valid   = 1'b1;
        Pred_Index   = idx;
        Pred_Counter = ctr;
        tick();
        Pred_Valid   = 1'b0;
    endtask

    task automatic resolve(input logic taken);
        Resolve_Valid = 1'b1;
        Resolve_Taken = taken;
        tick();
        Resolve_Valid = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0;
        BPU__Stall = 1'b0;
        Flush = 1'b0;
        Pred_Valid = 1'b0;
        Pred_Index = '0;
        Pred_Counter = '0;
        Resolve_Valid = 1'b0;
        Resolve_Taken = 1'b0;

        // Reset state, observed before any clock edge
        #2;
        check("rst_count", 32'(Count), 32'd0);
        check("rst_ready", 32'(Pred_Ready), 32'd1);
        check("rst_en", 32'(PHT_Write_En), 32'd0);
        check("rst_ghr_en", 32'(GHR_Write_En), 32'd0);
        check("rst_mispred", 32'(Mispredict), 32'd0);
        check("rst_underflow", 32'(Underflow_Err), 32'd0);
        check("rst_index", 32'(PHT_Write_Index), 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // Basic update: ctr 1 taken -> 2, mispredicted
        push(11'h155, 2'd1);
        check("a_count", 32'(Count), 32'd1);
        resolve(1'b1);
        check("a_en", 32'(PHT_Write_En), 32'd1);
        check("a_ghr_en", 32'(GHR_Write_En), 32'd1);
        check("a_index", 32'(PHT_Write_Index), 32'h155);
        check("a_data", 32'(PHT_Write_Data), 32'd2);
        check("a_ghr_data", 32'(GHR_Write_Data), 32'd1);
        check("a_mispred", 32'(Mispredict), 32'd1);
        check("a_count0", 32'(Count), 32'd0);
        tick();
        check("a_en_drop", 32'(PHT_Write_En), 32'd0);
        check("a_mispred_drop", 32'(Mispredict), 32'd0);

        // Saturation at both ends
        push(11'h020, 2'd3);
        push(11'h021, 2'd0);
        resolve(1'b1);
        check("sat_hi_index", 32'(PHT_Write_Index), 32'h020);
        check("sat_hi_data", 32'(PHT_Write_Data), 32'd3);
        check("sat_hi_mispred", 32'(Mispredict), 32'd0);
        check("sat_hi_en", 32'(PHT_Write_En), 32'd1);
        resolve(1'b0);
        check("sat_lo_index", 32'(PHT_Write_Index), 32'h021);
        check("sat_lo_data", 32'(PHT_Write_Data), 32'd0);
        check("sat_lo_mispred", 32'(Mispredict), 32'd0);
        check("sat_lo_ghr", 32'(GHR_Write_Data), 32'd0);
        check("sat_lo_en", 32'(PHT_Write_En), 32'd1);

        // Forwarding to a queued entry with the same index
        push(11'h010, 2'd1);
        push(11'h010, 2'd1);
        resolve(1'b1);
        check("fwd_q_data1", 32'(PHT_Write_Data), 32'd2);
        resolve(1'b1);
        check("fwd_q_data2", 32'(PHT_Write_Data), 32'd3);
        check("fwd_q_mispred2", 32'(Mispredict), 32'd0);

        // Forwarding into a same-cycle push
        push(11'h030, 2'd1);
        Pred_Valid = 1'b1; Pred_Index = 11'h030; Pred_Counter = 2'd1;
        resolve(1'b1);
        Pred_Valid = 1'b0;
        check("fwd_p_data1", 32'(PHT_Write_Data), 32'd2);
        check("fwd_p_count", 32'(Count), 32'd1);
        resolve(1'b1);
        check("fwd_p_data2", 32'(PHT_Write_Data), 32'd3);
        check("fwd_p_count0", 32'(Count), 32'd0);

        // Fill to full, drop a push at full
        for (int i = 0; i < 8; i++) begin
            push(11'(32'h40 + i), 2'(i));
            m_idx.push_back(11'(32'h40 + i));
            m_ctr.push_back(2'(i));
        end
        check("full_count", 32'(Count), 32'd8);
        check("full_ready", 32'(Pred_Ready), 32'd0);
        push(11'h099, 2'd2);
        check("drop_count", 32'(Count), 32'd8);

        // Pop+push at full across wrap; FIFO order must hold
        for (int k = 0; k < 21; k++) begin
            logic [10:0] eidx;
            logic [1:0]  ectr;
            logic        t;
            t = 1'(k % 2);
            eidx = m_idx.pop_front();
            ectr = m_ctr.pop_front();
            Pred_Valid = 1'b1;
            Pred_Index = 11'(32'h60 + k);
            Pred_Counter = 2'(k);
            resolve(t);
            Pred_Valid = 1'b0;
            m_idx.push_back(11'(32'h60 + k));
            m_ctr.push_back(2'(k));
            check($sformatf("wrap_index_%0d", k), 32'(PHT_Write_Index), 32'(eidx));
            check($sformatf("wrap_data_%0d", k), 32'(PHT_Write_Data), 32'(sat(ectr, t)));
            check($sformatf("wrap_mispred_%0d", k), 32'(Mispredict), 32'(ectr[1] ^ t));
            check($sformatf("wrap_count_%0d", k), 32'(Count), 32'd8);
        end

        // Flush while full
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("flush_full_count", 32'(Count), 32'd0);
        check("flush_full_ready", 32'(Pred_Ready), 32'd1);
        check("flush_full_en", 32'(PHT_Write_En), 32'd0);

        // Stall: resolve ignored, then pulse held through three stall cycles
        push(11'h070, 2'd2);
        BPU__Stall = 1'b1;
        resolve(1'b0);
        check("stall_res_count", 32'(Count), 32'd1);
        check("stall_res_en", 32'(PHT_Write_En), 32'd0);
        BPU__Stall = 1'b0;
        resolve(1'b0);
        check("stall_pop_index", 32'(PHT_Write_Index), 32'h070);
        check("stall_pop_data", 32'(PHT_Write_Data), 32'd1);
        check("stall_pop_mispred", 32'(Mispredict), 32'd1);
        BPU__Stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("stall_hold_en_%0d", s), 32'(PHT_Write_En), 32'd1);
            check($sformatf("stall_hold_mis_%0d", s), 32'(Mispredict), 32'd1);
        end
        BPU__Stall = 1'b0;
        tick();
        check("stall_release_en", 32'(PHT_Write_En), 32'd0);

        // Flush with Count=5, applied while stalled
        for (int i = 0; i < 5; i++) push(11'(32'h80 + i), 2'd1);
        check("flush5_pre", 32'(Count), 32'd5);
        BPU__Stall = 1'b1;
        Flush = 1'b1;
        tick();
        BPU__Stall = 1'b0;
        Flush = 1'b0;
        check("flush5_count", 32'(Count), 32'd0);

        // Underflow: resolve on empty queue
        resolve(1'b1);
        check("uflow_err", 32'(Underflow_Err), 32'd1);
        check("uflow_en", 32'(PHT_Write_En), 32'd0);
        check("uflow_count", 32'(Count), 32'd0);
        tick();
        check("uflow_drop", 32'(Underflow_Err), 32'd0);

        // Asynchronous reset mid-operation drops the pending pulse
        push(11'h155, 2'd1);
        push(11'h156, 2'd1);
        resolve(1'b1);
        check("areset_pre_en", 32'(PHT_Write_En), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("areset_en", 32'(PHT_Write_En), 32'd0);
        check("areset_count", 32'(Count), 32'd0);
        check("areset_ready", 32'(Pred_Ready), 32'd1);
        check("areset_index", 32'(PHT_Write_Index), 32'd0);
        check("areset_data", 32'(PHT_Write_Data), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
